// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, and an iterative
// 32-cycle unsigned multiply/divide unit that stalls the pipeline while busy.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  rdE,
  input  logic [15:0] imm16E,
  input  logic        extOpE,
  input  logic [3:0]  aluOpE,
  input  logic        aluSrc1_muxE,
  input  logic        aluSrc2_muxE,
  input  logic [1:0]  regDst_muxE,
  input  logic [31:0] readData1E,
  input  logic [31:0] readData2E,
  input  logic [31:0] pcE,
  input  logic [1:0]  forwardAE,
  input  logic [1:0]  forwardBE,
  input  logic [31:0] aluOutM,
  input  logic [31:0] resultW,
  input  logic        abortE,
  output logic [31:0] aluOutE,
  output logic [31:0] writeDataE,
  output logic [4:0]  writeRegE,
  output logic        stallE
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_LUI  = 4'hB;
  localparam logic [3:0] OP_MULU = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;
  localparam logic [3:0] OP_LINK = 4'hE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic [31:0] a_q;    // multiplicand (mul) / dividend shifting into quotient (div)
  logic [31:0] b_q;    // multiplier (mul) / divisor (div)
  logic [32:0] acc_q;  // product accumulator (mul) / partial remainder (div)

  logic [31:0] src_a, src_b, op_a, op_b, imm_ext, alu_comb, mc_result;
  logic [32:0] r_shift;
  logic        div_ge, is_mc;

  // rs is unused here: the hazard unit consumes it, the bundle just carries it.
  logic unused_rs;
  assign unused_rs = ^rsE;

  always_comb begin
    unique case (forwardAE)
      2'b01:   src_a = resultW;
      2'b10:   src_a = aluOutM;
      default: src_a = readData1E;
    endcase
    unique case (forwardBE)
      2'b01:   src_b = resultW;
      2'b10:   src_b = aluOutM;
      default: src_b = readData2E;
    endcase
  end

  assign imm_ext    = extOpE ? {{16{imm16E[15]}}, imm16E} : {16'h0, imm16E};
  assign op_a       = aluSrc1_muxE ? {27'b0, imm16E[10:6]} : src_a;
  assign op_b       = aluSrc2_muxE ? imm_ext : src_b;
  assign writeDataE = src_b;

  always_comb begin
    unique case (regDst_muxE)
      2'b00:   writeRegE = rtE;
      2'b01:   writeRegE = rdE;
      2'b10:   writeRegE = 5'd31;
      default: writeRegE = 5'd0;
    endcase
  end

  // NOTE: the default assignment before the case guarantees no latch is
  // inferred even when new opcodes are added without a matching branch.
  always_comb begin
    alu_comb = 32'h0;
    case (aluOpE)
      OP_ADD:  alu_comb = op_a + op_b;
      OP_SUB:  alu_comb = op_a - op_b;
      OP_AND:  alu_comb = op_a & op_b;
      OP_OR:   alu_comb = op_a | op_b;
      OP_XOR:  alu_comb = op_a ^ op_b;
      OP_NOR:  alu_comb = ~(op_a | op_b);
      OP_SLT:  alu_comb = {31'b0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_comb = {31'b0, op_a < op_b};
      OP_SLL:  alu_comb = op_b << op_a[4:0];
      OP_SRL:  alu_comb = op_b >> op_a[4:0];
      OP_SRA:  alu_comb = $unsigned($signed(op_b) >>> op_a[4:0]);
      OP_LUI:  alu_comb = {op_b[15:0], 16'h0};
      OP_LINK: alu_comb = pcE + 32'd8;
      default: alu_comb = 32'h0;
    endcase
  end

  // Restoring division step: shift the next dividend bit into the remainder.
  assign r_shift   = {acc_q[31:0], a_q[31]};
  assign div_ge    = r_shift >= {1'b0, b_q};
  assign mc_result = is_div ? a_q : acc_q[31:0];

  assign is_mc  = (aluOpE == OP_MULU) || (aluOpE == OP_DIVU);
  assign stallE = !abortE && (((state == IDLE) && is_mc) || (state == BUSY));
  assign aluOutE = (state == DONE) ? mc_result : alu_comb;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      acc_q  <= 33'h0;
    end else if (abortE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_mc) begin
            a_q    <= op_a;
            b_q    <= op_b;
            acc_q  <= 33'h0;
            cnt    <= 5'd0;
            is_div <= (aluOpE == OP_DIVU);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (is_div) begin
            a_q   <= {a_q[30:0], div_ge};
            acc_q <= div_ge ? (r_shift - {1'b0, b_q}) : r_shift;
          end else begin
            if (b_q[0]) acc_q <= acc_q + {1'b0, a_q};
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized ALU
// checks against a spec-level model, and multi-cycle mul/div sequences.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsE, rtE, rdE;
  logic [15:0] imm16E;
  logic        extOpE;
  logic [3:0]  aluOpE;
  logic        aluSrc1_muxE, aluSrc2_muxE;
  logic [1:0]  regDst_muxE;
  logic [31:0] readData1E, readData2E, pcE;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] aluOutM, resultW;
  logic        abortE;
  logic [31:0] aluOutE, writeDataE;
  logic [4:0]  writeRegE;
  logic        stallE;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .rsE(rsE), .rtE(rtE), .rdE(rdE), .imm16E(imm16E),
    .extOpE(extOpE), .aluOpE(aluOpE), .aluSrc1_muxE(aluSrc1_muxE),
    .aluSrc2_muxE(aluSrc2_muxE), .regDst_muxE(regDst_muxE),
    .readData1E(readData1E), .readData2E(readData2E), .pcE(pcE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .aluOutM(aluOutM),
    .resultW(resultW), .abortE(abortE), .aluOutE(aluOutE),
    .writeDataE(writeDataE), .writeRegE(writeRegE), .stallE(stallE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  fa, fb;
    logic        s1, s2, ext;
    logic [1:0]  rdst;
    logic [4:0]  rt, rd;
    logic [31:0] rd1, rd2, alum, resw;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] e_out;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    aluOpE = v.op; forwardAE = v.fa; forwardBE = v.fb;
    aluSrc1_muxE = v.s1; aluSrc2_muxE = v.s2; extOpE = v.ext;
    regDst_muxE = v.rdst; rtE = v.rt; rdE = v.rd; rsE = 5'd1;
    readData1E = v.rd1; readData2E = v.rd2; aluOutM = v.alum; resultW = v.resw;
    imm16E = v.imm; pcE = v.pc; abortE = 1'b0;
  endtask

  // Reference model written directly from the ISA-level rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    longint unsigned a, b, sa, sb;
    logic [31:0] srca, srcb;
    int sh;
    srca = (v.fa == 2'b01) ? v.resw : (v.fa == 2'b10) ? v.alum : v.rd1;
    srcb = (v.fb == 2'b01) ? v.resw : (v.fb == 2'b10) ? v.alum : v.rd2;
    a = v.s1 ? longint'(v.imm[10:6]) : longint'(srca);
    if (!v.s2)        b = longint'(srcb);
    else if (v.ext && v.imm[15]) b = 64'hFFFF_0000 + longint'(v.imm);
    else              b = longint'(v.imm);
    sh = int'(a % 32);
    sa = (a >= 64'h8000_0000) ? a - 64'h1_0000_0000 : a;
    sb = (b >= 64'h8000_0000) ? b - 64'h1_0000_0000 : b;
    case (v.op)
      4'h0: r.e_out = 32'((a + b) % 64'h1_0000_0000);
      4'h1: r.e_out = 32'((a + 64'h1_0000_0000 - b) % 64'h1_0000_0000);
      4'h2: r.e_out = 32'(a & b);
      4'h3: r.e_out = 32'(a | b);
      4'h4: r.e_out = 32'(a ^ b);
      4'h5: r.e_out = ~32'(a | b);
      4'h6: r.e_out = ($signed(sa) < $signed(sb)) ? 32'd1 : 32'd0;
      4'h7: r.e_out = (a < b) ? 32'd1 : 32'd0;
      4'h8: r.e_out = 32'((b * (64'd1 << sh)) % 64'h1_0000_0000);
      4'h9: r.e_out = 32'(b / (64'd1 << sh));
      4'hA: r.e_out = (b >= 64'h8000_0000)
                      ? ~32'((64'hFFFF_FFFF - b) / (64'd1 << sh))
                      : 32'(b / (64'd1 << sh));
      4'hB: r.e_out = 32'((b % 64'h1_0000) * 64'h1_0000);
      4'hE: r.e_out = v.pc + 32'd8;
      default: r.e_out = 32'h0;
    endcase
    r.e_wreg  = (v.rdst == 2'b00) ? v.rt : (v.rdst == 2'b01) ? v.rd :
                (v.rdst == 2'b10) ? 5'd31 : 5'd0;
    r.e_wdata = srcb;
    return r;
  endfunction

  // Runs one MULU/DIVU from IDLE; caller is just past a rising edge.
  task automatic run_mc(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    vec_t v = '{default: '0};
    logic [31:0] exp;
    int cycles = 0;
    exp = (op == 4'hC) ? 32'((longint'(a) * longint'(b)) % 64'h1_0000_0000)
                       : ((b == 0) ? 32'hFFFF_FFFF : a / b);
    v.op = op; v.rd1 = a; v.rd2 = b; v.rt = 5'd3; v.rd = 5'd7;
    drive(v);
    @(negedge clk);
    while (stallE && cycles < 40) begin
      cycles++;
      next_cycle();
      readData1E = $urandom; readData2E = $urandom;
      forwardAE = 2'($urandom_range(0, 3)); aluOutM = $urandom;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, 32'(cycles), 32'd33);
    check({name, "_result"}, aluOutE, exp);
    next_cycle();
  endtask

  vec_t vecs[12];
  vec_t rv, ev;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op    fa     fb     s1 s2 ex rdst   rt    rd    rd1           rd2           alum   resw          imm       pc       e_out          wreg   wdata
    vecs[0]  = '{4'h0, 2'b10, 2'b00, 0, 0, 0, 2'b00, 5'd3, 5'd7, 32'd0,        32'd7,        32'd5, 32'd0,        16'h0000, 32'h0,   32'd12,        5'd3,  32'd7};
    vecs[1]  = '{4'hA, 2'b00, 2'b01, 1, 0, 0, 2'b01, 5'd3, 5'd7, 32'd0,        32'd0,        32'd0, 32'h80000000, 16'h0100, 32'h0,   32'hF8000000,  5'd7,  32'h80000000};
    vecs[2]  = '{4'h6, 2'b00, 2'b00, 0, 0, 0, 2'b10, 5'd3, 5'd7, 32'hFFFFFFFF, 32'd1,        32'd0, 32'd0,        16'h0000, 32'h0,   32'd1,         5'd31, 32'd1};
    vecs[3]  = '{4'h7, 2'b00, 2'b00, 0, 0, 0, 2'b11, 5'd3, 5'd7, 32'hFFFFFFFF, 32'd1,        32'd0, 32'd0,        16'h0000, 32'h0,   32'd0,         5'd0,  32'd1};
    vecs[4]  = '{4'hE, 2'b00, 2'b00, 0, 0, 0, 2'b00, 5'd3, 5'd7, 32'd0,        32'd0,        32'd0, 32'd0,        16'h0000, 32'h100, 32'h108,       5'd3,  32'd0};
    vecs[5]  = '{4'hB, 2'b00, 2'b00, 0, 1, 1, 2'b00, 5'd3, 5'd7, 32'd0,        32'd0,        32'd0, 32'd0,        16'h1234, 32'h0,   32'h12340000,  5'd3,  32'd0};
    vecs[6]  = '{4'h0, 2'b11, 2'b00, 0, 1, 1, 2'b01, 5'd3, 5'd7, 32'd5,        32'd9,        32'd0, 32'd0,        16'hFFFF, 32'h0,   32'd4,         5'd7,  32'd9};
    vecs[7]  = '{4'h0, 2'b00, 2'b00, 0, 1, 0, 2'b01, 5'd3, 5'd7, 32'd1,        32'd0,        32'd0, 32'd0,        16'hFFFF, 32'h0,   32'h00010000,  5'd7,  32'd0};
    vecs[8]  = '{4'hF, 2'b00, 2'b00, 0, 0, 0, 2'b00, 5'd3, 5'd7, 32'h55,       32'h66,       32'd0, 32'd0,        16'h0000, 32'h0,   32'd0,         5'd3,  32'h66};
    vecs[9]  = '{4'h1, 2'b01, 2'b10, 0, 0, 0, 2'b00, 5'd3, 5'd7, 32'd0,        32'd0,        32'd3, 32'd10,       16'h0000, 32'h0,   32'd7,         5'd3,  32'd3};
    vecs[10] = '{4'h8, 2'b00, 2'b00, 1, 0, 0, 2'b00, 5'd3, 5'd7, 32'd0,        32'd1,        32'd0, 32'd0,        16'h07C0, 32'h0,   32'h80000000,  5'd3,  32'd1};
    vecs[11] = '{4'h5, 2'b00, 2'b00, 0, 0, 0, 2'b00, 5'd3, 5'd7, 32'h0F0F0F0F, 32'h00FF00FF, 32'd0, 32'd0,        16'h0000, 32'h0,   32'hF000F000,  5'd3,  32'h00FF00FF};

    rst = 1'b0;
    drive(vecs[0]);
    repeat (3) next_cycle();
    rst = 1'b1;
    rv = '{default: '0};
    rv.op = 4'h0; rv.rd1 = 32'd1; rv.rd2 = 32'd2; rv.rt = 5'd3;
    drive(rv);
    @(negedge clk);
    check("reset_stall", 32'(stallE), 32'd0);
    check("reset_add", aluOutE, 32'd3);
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_out", i), aluOutE, vecs[i].e_out);
      check($sformatf("vec%0d_wreg", i), 32'(writeRegE), 32'(vecs[i].e_wreg));
      check($sformatf("vec%0d_wdata", i), writeDataE, vecs[i].e_wdata);
      check($sformatf("vec%0d_stall", i), 32'(stallE), 32'd0);
      next_cycle();
    end

    for (int i = 0; i < 200; i++) begin
      int idx = $urandom_range(0, 13);
      rv.op = (idx < 12) ? 4'(idx) : 4'(idx + 2);
      rv.fa = 2'($urandom_range(0, 3)); rv.fb = 2'($urandom_range(0, 3));
      rv.s1 = 1'($urandom_range(0, 1)); rv.s2 = 1'($urandom_range(0, 1));
      rv.ext = 1'($urandom_range(0, 1)); rv.rdst = 2'($urandom_range(0, 3));
      rv.rt = 5'($urandom); rv.rd = 5'($urandom);
      rv.rd1 = $urandom; rv.rd2 = $urandom; rv.alum = $urandom; rv.resw = $urandom;
      rv.imm = 16'($urandom); rv.pc = $urandom;
      ev = model(rv);
      drive(rv);
      @(negedge clk);
      check($sformatf("rand%0d_op%h_out", i, rv.op), aluOutE, ev.e_out);
      check($sformatf("rand%0d_wreg", i), 32'(writeRegE), 32'(ev.e_wreg));
      check($sformatf("rand%0d_wdata", i), writeDataE, ev.e_wdata);
      next_cycle();
    end

    run_mc("mulu_dir", 4'hC, 32'h0001_0000, 32'h0003_0001);
    run_mc("divu_100_7", 4'hD, 32'd100, 32'd7);
    run_mc("divu_by0", 4'hD, 32'd12345, 32'd0);
    run_mc("b2b_divu", 4'hD, 32'hDEADBEEF, 32'd3);
    run_mc("b2b_mulu", 4'hC, 32'h1234_5678, 32'h9ABC_DEF1);
    for (int i = 0; i < 4; i++)
      run_mc($sformatf("rand_mc%0d", i), (i % 2 == 0) ? 4'hC : 4'hD, $urandom, $urandom);

    // Synchronous reset in the middle of a multiply.
    rv = '{default: '0};
    rv.op = 4'hC; rv.rd1 = 32'd77; rv.rd2 = 32'd99;
    drive(rv);
    repeat (10) next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1; aluOpE = 4'h0;
    @(negedge clk);
    check("rst_mid_stall", 32'(stallE), 32'd0);
    check("rst_mid_out", aluOutE, 32'd176);
    next_cycle();
    run_mc("after_rst_mulu", 4'hC, 32'd1000, 32'd1000);

    // Abort while BUSY.
    rv.op = 4'hD; rv.rd1 = 32'd500; rv.rd2 = 32'd9;
    drive(rv);
    repeat (5) next_cycle();
    abortE = 1'b1;
    @(negedge clk);
    check("abort_stall", 32'(stallE), 32'd0);
    next_cycle();
    abortE = 1'b0; aluOpE = 4'h0;
    @(negedge clk);
    check("abort_idle", 32'(stallE), 32'd0);
    next_cycle();
    run_mc("after_abort_mulu", 4'hC, 32'd123, 32'd456);

    // Abort beats a new op arriving in IDLE.
    rv.op = 4'hD; rv.rd1 = 32'd81; rv.rd2 = 32'd9;
    drive(rv);
    abortE = 1'b1;
    @(negedge clk);
    check("abort_idle_prio", 32'(stallE), 32'd0);
    next_cycle();
    run_mc("after_abort_divu", 4'hD, 32'd81, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- rsE, rtE, rdE  in  5 each  register numbers from the ID/EX register.
- imm16E  in  16  immediate.
- extOpE  in  1  1 = sign-extend imm16E, 0 = zero-extend.
- aluOpE  in  4  operation code.
- aluSrc1_muxE, aluSrc2_muxE  in  1 each  operand selects.
- regDst_muxE  in  2  destination select.
- readData1E, readData2E  in  32 each  register file data.
- pcE  in  32  instruction PC.
- forwardAE, forwardBE  in  2 each  forwarding selects from the hazard unit.
- aluOutM, resultW  in  32 each  forwarded MEM and WB values.
- abortE  in  1  cancels an in-flight multi-cycle operation.
- aluOutE  out  32  execute result.
- writeDataE  out  32  forwarded rt value, used as store data.
- writeRegE  out  5  destination register.
- stallE  out  1  multi-cycle unit busy; the hazard unit freezes PC, IF/ID and ID/EX while it is high.

Function
REQ-002 Forwarded rs value (srcA):
- forwardAE 00 or 11 → readData1E.
- forwardAE 01 → resultW.
- forwardAE 10 → aluOutM.
REQ-003 Forwarded rt value (srcB) SHALL use forwardBE with the same encoding as REQ-002; writeDataE = srcB.
REQ-004 Operand A SHALL be srcA when aluSrc1_muxE=0, and {27'b0, imm16E[10:6]} (shamt) when aluSrc1_muxE=1.
REQ-005 Operand B SHALL be srcB when aluSrc2_muxE=0, and imm16E extended per extOpE to 32 bits when aluSrc2_muxE=1.
REQ-006 writeRegE SHALL be: regDst_muxE 00 → rtE; 01 → rdE; 10 → 5'd31; 11 → 5'd0.
REQ-007 Single-cycle ops SHALL be combinational, with A = operand A and B = operand B:
- 0 ADD: A+B, mod 2^32, no overflow trap.
- 1 SUB: A-B.
- 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLT: signed compare, result 0 or 1.
- 7 SLTU: unsigned compare, result 0 or 1.
- 8 SLL: B<<A[4:0].
- 9 SRL: B>>A[4:0], logical.
- A SRA: B>>>A[4:0], arithmetic.
- B LUI: {B[15:0],16'h0}.
- E LINK: pcE+8.
- F: 32'h0.
REQ-008 Op C MULU SHALL produce the low 32 bits of the unsigned product; op D DIVU SHALL produce the unsigned quotient. Both SHALL be computed iteratively, one bit per cycle (shift-add / restoring division).
REQ-009 The multi-cycle FSM SHALL have states IDLE, BUSY and DONE, plus a 5-bit counter.
- IDLE: when aluOpE is C or D, latch operand A and operand B, clear the counter, go to BUSY. stallE=1 in that same cycle (combinational from aluOpE and state).
- BUSY: one iteration per cycle; counter increments 0..31; after the iteration at counter=31, go to DONE. stallE=1.
- DONE: aluOutE = latched result; stallE=0; go to IDLE next cycle.
REQ-010 Latency SHALL be: op present in EX at cycle T → stallE high for cycles T..T+32 (33 cycles) → result on aluOutE with stallE low at cycle T+33.
REQ-011 A multi-cycle op that immediately follows another SHALL start a fresh operation from IDLE. DONE never re-triggers on the same instruction.
REQ-012 DIVU by zero SHALL give quotient 32'hFFFFFFFF and the normal 33-cycle latency.
REQ-013 abortE=1 in any state SHALL force IDLE on the next edge. stallE SHALL be 0 in a cycle where abortE=1. abortE takes priority over a new C/D op in IDLE.
REQ-014 While BUSY, changes on the operand and forwarding inputs SHALL NOT affect the result (operands are latched).

Reset
REQ-015 When rst=0 at a clk edge, the FSM SHALL go to IDLE and the counter and all operand/result registers SHALL clear to 0, including mid-operation; the partial result is discarded.
REQ-016 After reset, stallE SHALL be 0 unless aluOpE is C/D. All other outputs SHALL be combinational functions of the inputs.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- ADD with forwardAE=10, aluOutM=5, readData2E=7, aluSrc2_muxE=0 → aluOutE=12.
- SRA, shamt imm16E[10:6]=4, srcB=32'h80000000 → 32'hF8000000; SLT with -1 vs 1 → 1; SLTU with the same operands → 0.
- MULU 32'h0001_0000 × 32'h0003_0001 → stallE high 33 cycles; then aluOutE=32'h0001_0000, stallE=0.
- DIVU 100/7 → 14; DIVU x/0 → 32'hFFFFFFFF; back-to-back DIVU then MULU → two separate 33-cycle stalls.
- rst=0 at cycle 10 of a MULU → IDLE next cycle, stallE drops when aluOpE≠C/D.
- abortE pulsed during BUSY → IDLE next cycle; a new op then completes correctly.
- regDst_muxE=10 → writeRegE=31; op E with pcE=32'h100 → aluOutE=32'h108.
